// File: rtl/image_pkg.sv
// -----------------------------------------------------------------------------
// image_pkg
// Shared definitions for the frame-capture path:
//   DEFAULT_WIDTH / DEFAULT_HEIGHT : default image geometry in pixels / lines
//   BMP_HEADER_NUM                 : byte length of a BMP file header
//   capture_state_t                : capture FSM state encoding
// -----------------------------------------------------------------------------
package image_pkg;

   localparam int DEFAULT_WIDTH  = 768;
   localparam int DEFAULT_HEIGHT = 512;
   localparam int BMP_HEADER_NUM = 54;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LINE = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } capture_state_t;

endpackage

// File: rtl/bmp_addr_gen.sv
// -----------------------------------------------------------------------------
// bmp_addr_gen
// Maps a (row, col) pixel-pair position to a bottom-up frame-memory word
// address, so line 0 lands in the last line of memory as BMP files expect:
//   addr = (HEIGHT-1-row) * (WIDTH/2) + col
// Ports:
//   row  : in,  current line index 0..HEIGHT-1
//   col  : in,  current pair index 0..WIDTH/2-1
//   addr : out, word address (combinational)
// -----------------------------------------------------------------------------
module bmp_addr_gen
   import image_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int HEIGHT = DEFAULT_HEIGHT,
   parameter int AW     = $clog2(WIDTH * HEIGHT / 2),
   parameter int CW     = $clog2(WIDTH / 2),
   parameter int RW     = $clog2(HEIGHT)
)(
   input  logic [RW-1:0] row,
   input  logic [CW-1:0] col,
   output logic [AW-1:0] addr
);

   localparam logic [AW-1:0] LAST_ROW  = AW'(HEIGHT - 1);
   localparam logic [AW-1:0] LINE_PAIRS = AW'(WIDTH / 2);

   // All operands widened to the full address width before the multiply so
   // nothing is truncated for large frames.
   assign addr = (LAST_ROW - AW'(row)) * LINE_PAIRS + AW'(col);

endmodule

// File: rtl/image_capture.sv
// -----------------------------------------------------------------------------
// image_capture
// Captures one frame of pixel pairs into frame memory, one 48-bit word per
// pair, lines stored bottom-up. The frame ends after the last pair of the last
// line; further input is ignored until reset.
// Ports:
//   HCLK, HRESET          : clock, synchronous active-high reset
//   HSYNC                 : 1 = valid pixel pair this cycle, 0 = line gap
//   DATA_WRITE_R0/G0/B0   : even pixel
//   DATA_WRITE_R1/G1/B1   : odd pixel
//   mem_we/addr/wdata     : registered frame-memory write port
//   Write_Done            : sticky, frame fully stored
//   frame_err             : sticky, a line ended early
// Configuration macro:
//   BGR_ORDER_EN : pack each pixel B,G,R in ascending byte order (BMP order);
//                  when undefined, byte 0 is R0.
// -----------------------------------------------------------------------------
module image_capture
   import image_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int HEIGHT = DEFAULT_HEIGHT
)(
   input  logic                               HCLK,
   input  logic                               HRESET,
   input  logic                               HSYNC,
   input  logic [7:0]                         DATA_WRITE_R0,
   input  logic [7:0]                         DATA_WRITE_G0,
   input  logic [7:0]                         DATA_WRITE_B0,
   input  logic [7:0]                         DATA_WRITE_R1,
   input  logic [7:0]                         DATA_WRITE_G1,
   input  logic [7:0]                         DATA_WRITE_B1,
   output logic                               mem_we,
   output logic [$clog2(WIDTH*HEIGHT/2)-1:0]  mem_addr,
   output logic [47:0]                        mem_wdata,
   output logic                               Write_Done,
   output logic                               frame_err
);

   localparam int AW = $clog2(WIDTH * HEIGHT / 2);
   localparam int CW = $clog2(WIDTH / 2);
   localparam int RW = $clog2(HEIGHT);

   capture_state_t state_reg, state_next;
   logic [CW-1:0]  col_reg, col_next;
   logic [RW-1:0]  row_reg, row_next;
   logic           sample, last_pair, err_set;
   logic           col_last, row_last;
   logic [AW-1:0]  pair_addr;
   logic [47:0]    pair_data;

   logic           we_reg;
   logic [AW-1:0]  addr_reg;
   logic [47:0]    wdata_reg;
   logic           done_reg;
   logic           err_reg;

`ifdef BGR_ORDER_EN
   assign pair_data = {DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1,
                       DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0};
`else
   assign pair_data = {DATA_WRITE_B1, DATA_WRITE_G1, DATA_WRITE_R1,
                       DATA_WRITE_B0, DATA_WRITE_G0, DATA_WRITE_R0};
`endif

   bmp_addr_gen #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .AW     (AW),
      .CW     (CW),
      .RW     (RW)
   ) u_addr_gen (
      .row  (row_reg),
      .col  (col_reg),
      .addr (pair_addr)
   );

   assign col_last = (col_reg == CW'(WIDTH / 2 - 1));
   assign row_last = (row_reg == RW'(HEIGHT - 1));

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      col_next   = col_reg;
      row_next   = row_reg;
      sample     = 1'b0;
      last_pair  = 1'b0;
      err_set    = 1'b0;

      case (state_reg)
         IDLE:    if (HSYNC)  state_next = LINE;
         LINE:    if (!HSYNC) state_next = GAP;
         GAP:     if (HSYNC)  state_next = LINE;
         default: state_next = DONE;
      endcase

      if (state_reg != DONE) begin
         if (HSYNC) begin
            sample = 1'b1;
            if (col_last) begin
               col_next = '0;
               // Row wrap keeps the address in range; after the final pair
               // the FSM parks in DONE so the wrapped row is never used.
               row_next = row_last ? '0 : row_reg + 1'b1;
               if (row_last) begin
                  last_pair  = 1'b1;
                  state_next = DONE;
               end
            end else begin
               col_next = col_reg + 1'b1;
            end
         end else if (state_reg == LINE && col_reg != '0) begin
            // Line ended early: drop the partial line and realign on the next.
            err_set  = 1'b1;
            col_next = '0;
            row_next = row_last ? '0 : row_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         col_reg   <= '0;
         row_reg   <= '0;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         col_reg <= col_next;
         row_reg <= row_next;
         we_reg  <= sample;
         if (sample) begin
            addr_reg  <= pair_addr;
            wdata_reg <= pair_data;
         end
         // Set together with the final write strobe.
         if (last_pair) done_reg <= 1'b1;
         if (err_set)   err_reg  <= 1'b1;
      end
   end

   assign mem_we     = we_reg;
   assign mem_addr   = addr_reg;
   assign mem_wdata  = wdata_reg;
   assign Write_Done = done_reg;
   assign frame_err  = err_reg;

endmodule

// File: doc/image_capture.md
IMAGE_CAPTURE -- requirements
Module: image_capture

Interface
REQ-001 Parameter WIDTH, default 768: image width in pixels; even, >= 4.
REQ-002 Parameter HEIGHT, default 512: image height in lines, >= 2.
REQ-003 Port HCLK, input, 1: single clock; all logic on rising edge.
REQ-004 Port HRESET, input, 1: synchronous active-high reset.
REQ-005 Port HSYNC, input, 1: high marks a valid pixel pair this cycle; low marks the inter-line gap.
REQ-006 Ports DATA_WRITE_R0/G0/B0, input, 8 each: even pixel.
REQ-007 Ports DATA_WRITE_R1/G1/B1, input, 8 each: odd pixel.
REQ-008 Port mem_we, output, 1: frame-memory write strobe.
REQ-009 Port mem_addr, output, clog2(WIDTH*HEIGHT/2): word address, one word per pixel pair.
REQ-010 Port mem_wdata, output, 48: packed pixel pair.
REQ-011 Port Write_Done, output, 1: frame fully stored; sticky.
REQ-012 Port frame_err, output, 1: sticky protocol-error flag.

Function
REQ-013 FSM states: IDLE, LINE, GAP, DONE. IDLE->LINE on HSYNC=1. LINE->GAP on HSYNC=0. GAP->LINE on HSYNC=1. Any state->DONE when the last pair of line HEIGHT-1 is sampled.
REQ-014 Each HSYNC=1 cycle outside DONE samples one pair; col counts 0..WIDTH/2-1, row counts 0..HEIGHT-1.
REQ-015 On col=WIDTH/2-1: col wraps to 0, row increments. A line continuing while HSYNC stays high is legal and raises no error.
REQ-016 HSYNC falling with col!=0: frame_err=1, col=0, row increments (short line discarded from alignment).
REQ-017 Address is bottom-up: mem_addr=(HEIGHT-1-row)*(WIDTH/2)+col.
REQ-018 Write latency 1 cycle: mem_we, mem_addr, mem_wdata registered; mem_we high exactly one cycle per sampled pair.
REQ-019 Default packing: mem_wdata[47:0]={B1,G1,R1,B0,G0,R0}, i.e. byte 0 = R0.
REQ-020 Write_Done rises in the cycle mem_we carries the final write (address 0-based word WIDTH/2-1); it stays high until reset.
REQ-021 In DONE, HSYNC and data are ignored; mem_we stays 0.
REQ-022 Address arithmetic is unsigned, full-width; no truncation for default parameters (18 bits).

Reset
REQ-023 HRESET=1 at an edge: state=IDLE, row=0, col=0, mem_we=0, mem_addr=0, mem_wdata=0, Write_Done=0, frame_err=0.
REQ-024 Reset mid-frame discards progress; the next HSYNC=1 is treated as pixel (0,0) of a new frame.
REQ-025 Reset dominates a simultaneous HSYNC=1; that pair is not written.

Configuration
REQ-026 Macro BGR_ORDER_EN: when defined, each pixel is packed B,G,R in ascending byte order (mem_wdata={R1,G1,B1,R0,G0,B0}), matching BMP byte order; when undefined, REQ-019 packing applies. No other behaviour changes.

Structure
REQ-027 Package image_pkg holds the default WIDTH/HEIGHT, BMP_HEADER_NUM=54, and the capture-state enum typedef.
REQ-028 Sub-module bmp_addr_gen computes the bottom-up word address from row/col; FSM, counters and packing stay in image_capture.

Verification (bench WIDTH=8, HEIGHT=4 unless stated)
REQ-029 Reset, then 4 lines of 4 HSYNC cycles each separated by 3-cycle gaps -> 16 writes; first address 12, line order 12..15, 8..11, 4..7, 0..3; Write_Done=1 with the write to address 3; frame_err=0.
REQ-030 Pair R0=0x11,G0=0x22,B0=0x33,R1=0x44,G1=0x55,B1=0x66 -> mem_wdata=0x665544332211; with BGR_ORDER_EN -> 0x445566112233.
REQ-031 Line 1 with HSYNC high for only 2 cycles -> frame_err=1 one cycle later, next line writes begin at address 4 (row 2).
REQ-032 HSYNC held high continuously 16 cycles -> same 16 addresses as REQ-029, frame_err=0.
REQ-033 HRESET asserted after 6 pairs, then full frame -> Write_Done=0 after reset, restart at address 12, frame completes normally.
REQ-034 Extra HSYNC=1 cycles after Write_Done -> mem_we stays 0, Write_Done stays 1.
